// File: rtl/pst_alt_trial_sequencer.sv
// Sequencer for the alternating-input convergence trial on two pst_2layer instances:
// drives input_current and records per-transition convergence latency of each instance.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for start after reset
// WARMUP | cur_out at CUR_HI, counting WARMUP_CYC gamma cycles
// MEAS   | observing err_a/err_b for MEAS_CYC gamma cycles after a transition
// SETTLE | waiting SETTLE_CYC gamma cycles before the next transition
// DONE   | trial finished, table readable, waiting for restart
module pst_alt_trial_sequencer #(
  parameter logic [7:0] CUR_HI     = 8'd200,
  parameter logic [7:0] CUR_LO     = 8'd5,
  parameter logic [7:0] WARMUP_CYC = 8'd30,
  parameter logic [4:0] MEAS_CYC   = 5'd16,
  parameter logic [7:0] SETTLE_CYC = 8'd15,
  parameter logic [3:0] N_TRANS    = 4'd6,
  parameter logic [7:0] ERR_TOL    = 8'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cycle_start,
  input  logic [7:0] err_a,
  input  logic [7:0] err_b,
  output logic [7:0] cur_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] trans_idx,
  output logic       trans_pulse,
  input  logic [2:0] rd_idx,
  output logic [4:0] rd_lat_a,
  output logic [4:0] rd_lat_b,
  output logic [3:0] a_faster_cnt,
  output logic       late_a_wins
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WARMUP = 3'd1;
  localparam logic [2:0] S_MEAS   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state;
  logic [7:0] tmr;
  logic [4:0] lat_a_q;
  logic [4:0] lat_b_q;
  logic [4:0] tab_a [8];
  logic [4:0] tab_b [8];

  logic       tmr_tc;
  logic [4:0] meas_k;
  logic [4:0] lat_a_now;
  logic [4:0] lat_b_now;
  logic [4:0] fin_a;
  logic [4:0] fin_b;
  logic       a_wins;
  logic       last_trans;
  logic       late_window;
  logic [2:0] next_idx;
  logic [7:0] next_cur;

  // tmr counts remaining gamma cycles; 0 or 1 both mean "this pulse ends the state"
  assign tmr_tc = (tmr <= 8'd1);
  assign meas_k = MEAS_CYC - tmr[4:0] + 5'd1;

  // A latched latency of 0 means "not converged yet" (k starts at 1)
  assign lat_a_now = (lat_a_q != 5'd0) ? lat_a_q : ((err_a <= ERR_TOL) ? meas_k : 5'd0);
  assign lat_b_now = (lat_b_q != 5'd0) ? lat_b_q : ((err_b <= ERR_TOL) ? meas_k : 5'd0);
  assign fin_a = (lat_a_now != 5'd0) ? lat_a_now : MEAS_CYC;
  assign fin_b = (lat_b_now != 5'd0) ? lat_b_now : MEAS_CYC;
  assign a_wins = (fin_a < fin_b);

  assign last_trans  = ({1'b0, trans_idx} == (N_TRANS - 4'd1));
  assign late_window = (({1'b0, trans_idx} + 4'd2) >= N_TRANS);
  assign next_idx    = trans_idx + 3'd1;
  // Transition 0 goes to LO, then the current alternates: odd transitions land on HI
  assign next_cur    = next_idx[0] ? CUR_HI : CUR_LO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tmr          <= 8'd0;
      lat_a_q      <= 5'd0;
      lat_b_q      <= 5'd0;
      cur_out      <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      trans_idx    <= 3'd0;
      trans_pulse  <= 1'b0;
      a_faster_cnt <= 4'd0;
      late_a_wins  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        tab_a[i] <= 5'd0;
        tab_b[i] <= 5'd0;
      end
    end else begin
      trans_pulse <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_WARMUP;
            tmr          <= WARMUP_CYC;
            cur_out      <= CUR_HI;
            busy         <= 1'b1;
            done         <= 1'b0;
            trans_idx    <= 3'd0;
            a_faster_cnt <= 4'd0;
            late_a_wins  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
              tab_a[i] <= 5'd0;
              tab_b[i] <= 5'd0;
            end
          end
        end
        S_WARMUP: begin
          if (cycle_start) begin
            if (tmr_tc) begin
              state       <= S_MEAS;
              tmr         <= {3'b000, MEAS_CYC};
              trans_idx   <= 3'd0;
              cur_out     <= CUR_LO;
              trans_pulse <= 1'b1;
              lat_a_q     <= 5'd0;
              lat_b_q     <= 5'd0;
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
        end
        S_MEAS: begin
          if (cycle_start) begin
            lat_a_q <= lat_a_now;
            lat_b_q <= lat_b_now;
            if (tmr_tc) begin
              tab_a[trans_idx] <= fin_a;
              tab_b[trans_idx] <= fin_b;
              a_faster_cnt     <= a_faster_cnt + {3'b000, a_wins};
              if (late_window && a_wins) begin
                late_a_wins <= 1'b1;
              end
              if (last_trans) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (SETTLE_CYC == 8'd0) begin
                tmr         <= {3'b000, MEAS_CYC};
                trans_idx   <= next_idx;
                cur_out     <= next_cur;
                trans_pulse <= 1'b1;
                lat_a_q     <= 5'd0;
                lat_b_q     <= 5'd0;
              end else begin
                state <= S_SETTLE;
                tmr   <= SETTLE_CYC;
              end
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
        end
        S_SETTLE: begin
          if (cycle_start) begin
            if (tmr_tc) begin
              state       <= S_MEAS;
              tmr         <= {3'b000, MEAS_CYC};
              trans_idx   <= next_idx;
              cur_out     <= next_cur;
              trans_pulse <= 1'b1;
              lat_a_q     <= 5'd0;
              lat_b_q     <= 5'd0;
            end else begin
              tmr <= tmr - 8'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_lat_a = 5'd0;
    rd_lat_b = 5'd0;
    if ({1'b0, rd_idx} < N_TRANS) begin
      rd_lat_a = tab_a[rd_idx];
      rd_lat_b = tab_b[rd_idx];
    end
  end

endmodule
